// File: rtl/vcr_pkg.sv
// Shared VCR address map and error-bit layout, also consumed by the EZ-USB firmware header generator.
package vcr_pkg;

    localparam logic [7:0] VCR_HS_ON      = 8'h80;
    localparam logic [7:0] VCR_HS_OFF     = 8'h81;
    localparam logic [7:0] VCR_APP_MODE   = 8'h82;
    localparam logic [7:0] VCR_LIMIT_MIN  = 8'h83;
    localparam logic [7:0] VCR_IO_STATUS  = 8'h84;
    localparam logic [7:0] VCR_OUT_LIMIT  = 8'h85;
    localparam logic [7:0] VCR_MODE_LIMIT = 8'h86;
    localparam logic [7:0] VCR_MODE_FREE  = 8'h87;
    localparam logic [7:0] VCR_ECHO       = 8'h88;
    localparam logic [7:0] VCR_FPGA_ID    = 8'h8A;
    localparam logic [7:0] VCR_SOFT_RESET = 8'h8B;
    localparam logic [7:0] VCR_ERR        = 8'h8C;
    localparam logic [7:0] VCR_ID_DATA    = 8'hA1;
    localparam logic [7:0] VCR_APP_BASE   = 8'h90;

    localparam int ERR_BAD_ADDR  = 0;
    localparam int ERR_OVERRUN   = 1;
    localparam int ERR_COLLISION = 2;
    localparam int ERR_W         = 3;

    // Wide enough to index past the largest register/status window before saturating.
    localparam int BIDX_W = 5;

    function automatic logic is_app_addr(input logic [7:0] a, input int n_regs);
        return (int'(a) >= int'(VCR_APP_BASE)) && (int'(a) < int'(VCR_APP_BASE) + n_regs);
    endfunction

endpackage

// File: rtl/vcr_strobe_sync.sv
// Brings one asynchronous VCR strobe into the IFCLK domain as a single-cycle rising-edge pulse.
module vcr_strobe_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_strobe,
    output logic o_pulse
);

    // [0],[1] are the synchroniser, [2] is the edge-detect history.
    logic [2:0] r_sh;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh <= '0;
        end else begin
            r_sh <= {r_sh[1:0], i_strobe};
        end
    end

    assign o_pulse = r_sh[1] & ~r_sh[2];

endmodule

// File: rtl/vcr_regfile.sv
// Second-generation VCR endpoint: strobe-driven command/register file between the EZ-USB
// control path and the IFCLK-domain hs_io, output-limit and application logic.
module vcr_regfile
    import vcr_pkg::*;
#(
    parameter int          N_APP_REGS     = 4,
    parameter int          REG_BYTES      = 4,
    parameter int          ECHO_DEPTH     = 4,
    parameter int          STATUS_BYTES   = 6,
    parameter int          RESET_TIMER_W  = 4,
    parameter logic [15:0] BITSTREAM_TYPE = 16'h0002
) (
    input  logic                                IFCLK,
    input  logic                                RESET,
    input  logic                                CS,
    input  logic [7:0]                          vcr_in,
    output logic [7:0]                          vcr_out,
    input  logic                                clk_vcr_addr,
    input  logic                                clk_vcr_data,
    input  logic [2:0]                          FPGA_ID,
    input  logic [8*STATUS_BYTES-1:0]           status_in,
    input  logic [15:0]                         output_limit,
    output logic                                hs_en,
    output logic                                output_mode_limit,
    output logic [15:0]                         output_limit_min,
    output logic                                reg_output_limit,
    output logic [8*REG_BYTES*N_APP_REGS-1:0]   app_regs,
    output logic [N_APP_REGS-1:0]               app_reg_wr,
    output logic                                RESET_OUT
);

    localparam int ECHO_AW = $clog2(ECHO_DEPTH);

    // Handshake: each rising edge of clk_vcr_addr / clk_vcr_data is exactly one transfer while CS
    // is high; the EZ-USB samples vcr_out before raising clk_vcr_data, which then advances byte_idx.
    logic w_addr_pulse;
    logic w_data_pulse;
    logic w_addr_en;
    logic w_data_en;
    logic w_collision;
    logic w_idle;
    logic [REG_BYTES-1:0][7:0] w_commit;
    logic [7:0] w_rd_byte;

    logic [7:0]                                 r_vcr_addr;
    logic [BIDX_W-1:0]                          r_byte_idx;
    logic [ERR_W-1:0]                           r_err;
    logic                                       r_hs_en;
    logic                                       r_mode_limit;
    logic [15:0]                                r_limit_min;
    logic                                       r_reg_ol;
    logic [N_APP_REGS-1:0][8*REG_BYTES-1:0]     r_app;
    logic [N_APP_REGS-1:0]                      r_app_wr;
    logic [REG_BYTES-1:0][7:0]                  r_shadow;
    logic [ECHO_DEPTH-1:0][7:0]                 r_echo;
    logic [RESET_TIMER_W-1:0]                   r_reset_timer;
    logic [7:0]                                 r_vcr_out;

    vcr_strobe_sync u_addr_sync (
        .i_clk    (IFCLK),
        .i_rst    (RESET),
        .i_strobe (clk_vcr_addr),
        .o_pulse  (w_addr_pulse)
    );

    vcr_strobe_sync u_data_sync (
        .i_clk    (IFCLK),
        .i_rst    (RESET),
        .i_strobe (clk_vcr_data),
        .o_pulse  (w_data_pulse)
    );

    assign w_addr_en   = w_addr_pulse & CS;
    assign w_collision = w_addr_en & w_data_pulse;
    assign w_data_en   = w_data_pulse & CS & ~w_addr_pulse;
    assign w_idle      = ~(w_addr_en | (w_data_pulse & CS));

    always_comb begin
        w_commit              = r_shadow;
        w_commit[REG_BYTES-1] = vcr_in;
    end

    always_ff @(posedge IFCLK) begin
        if (RESET) begin
            r_vcr_addr    <= '0;
            r_byte_idx    <= '0;
            r_err         <= '0;
            r_hs_en       <= 1'b0;
            r_mode_limit  <= 1'b1;
            r_limit_min   <= '0;
            r_reg_ol      <= 1'b0;
            r_app         <= '0;
            r_app_wr      <= '0;
            r_shadow      <= '0;
            r_echo        <= '0;
            r_reset_timer <= '0;
        end else begin
            r_reg_ol <= 1'b0;
            r_app_wr <= '0;
            if (w_idle && !(&r_reset_timer)) begin
                r_reset_timer <= r_reset_timer + RESET_TIMER_W'(1);
            end

            if (w_addr_en) begin
                r_vcr_addr <= vcr_in;
                r_byte_idx <= '0;
                r_shadow   <= '0;
                if (w_collision) begin
                    r_err[ERR_COLLISION] <= 1'b1;
                end
                case (vcr_in)
                    VCR_HS_ON:      r_hs_en      <= 1'b1;
                    VCR_HS_OFF:     r_hs_en      <= 1'b0;
                    VCR_MODE_LIMIT: r_mode_limit <= 1'b1;
                    VCR_MODE_FREE:  r_mode_limit <= 1'b0;
                    VCR_OUT_LIMIT:  r_reg_ol     <= 1'b1;
                    // Soft reset mirrors RESET but leaves hs_en and the echo contents alone.
                    VCR_SOFT_RESET: begin
                        r_vcr_addr    <= '0;
                        r_err         <= '0;
                        r_mode_limit  <= 1'b1;
                        r_limit_min   <= '0;
                        r_app         <= '0;
                        r_reset_timer <= '0;
                    end
                    VCR_APP_MODE, VCR_LIMIT_MIN, VCR_IO_STATUS, VCR_ECHO,
                    VCR_FPGA_ID, VCR_ERR, VCR_ID_DATA: ;
                    default: begin
                        if (!is_app_addr(vcr_in, N_APP_REGS)) begin
                            r_err[ERR_BAD_ADDR] <= 1'b1;
                        end
                    end
                endcase
            end else if (w_data_en) begin
                if (r_byte_idx != '1) begin
                    r_byte_idx <= r_byte_idx + BIDX_W'(1);
                end
                if (r_vcr_addr == VCR_APP_MODE) begin
                    r_app[0][7:0] <= vcr_in;
                    r_app_wr[0]   <= 1'b1;
                end
                if (r_vcr_addr == VCR_LIMIT_MIN) begin
                    if (r_byte_idx == '0) begin
                        r_limit_min[7:0] <= vcr_in;
                    end else if (r_byte_idx == BIDX_W'(1)) begin
                        r_limit_min[15:8] <= vcr_in;
                    end
                end
                if (r_vcr_addr == VCR_ECHO) begin
                    r_echo[r_byte_idx[ECHO_AW-1:0]] <= vcr_in;
                end
                for (int i = 0; i < N_APP_REGS; i++) begin
                    if (r_vcr_addr == VCR_APP_BASE + 8'(i)) begin
                        if (r_byte_idx < BIDX_W'(REG_BYTES)) begin
                            for (int b = 0; b < REG_BYTES; b++) begin
                                if (r_byte_idx == BIDX_W'(b)) begin
                                    r_shadow[b] <= vcr_in;
                                end
                            end
                            if (r_byte_idx == BIDX_W'(REG_BYTES - 1)) begin
                                r_app[i]    <= w_commit;
                                r_app_wr[i] <= 1'b1;
                            end
                        end else begin
                            r_err[ERR_OVERRUN] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        w_rd_byte = '0;
        case (r_vcr_addr)
            VCR_IO_STATUS: begin
                for (int s = 0; s < STATUS_BYTES; s++) begin
                    if (r_byte_idx == BIDX_W'(s)) begin
                        w_rd_byte = status_in[8*s +: 8];
                    end
                end
            end
            VCR_OUT_LIMIT: begin
                if (r_byte_idx == '0) begin
                    w_rd_byte = output_limit[7:0];
                end else if (r_byte_idx == BIDX_W'(1)) begin
                    w_rd_byte = output_limit[15:8];
                end
            end
            VCR_ECHO:    w_rd_byte = r_echo[r_byte_idx[ECHO_AW-1:0]] ^ 8'h5A;
            VCR_FPGA_ID: w_rd_byte = {5'b0, FPGA_ID};
            VCR_ERR:     w_rd_byte = {5'b0, r_err};
            VCR_ID_DATA: begin
                if (r_byte_idx == '0) begin
                    w_rd_byte = BITSTREAM_TYPE[7:0];
                end else if (r_byte_idx == BIDX_W'(1)) begin
                    w_rd_byte = BITSTREAM_TYPE[15:8];
                end
            end
            default: begin
                for (int i = 0; i < N_APP_REGS; i++) begin
                    for (int b = 0; b < REG_BYTES; b++) begin
                        if (r_vcr_addr == VCR_APP_BASE + 8'(i) && r_byte_idx == BIDX_W'(b)) begin
                            w_rd_byte = r_app[i][8*b +: 8];
                        end
                    end
                end
            end
        endcase
    end

    // Registered every cycle so the byte is settled long before the next data strobe lands.
    always_ff @(posedge IFCLK) begin
        if (RESET) begin
            r_vcr_out <= '0;
        end else begin
            r_vcr_out <= w_rd_byte;
        end
    end

    assign vcr_out           = r_vcr_out;
    assign hs_en             = r_hs_en;
    assign output_mode_limit = r_mode_limit;
    assign output_limit_min  = r_limit_min;
    assign reg_output_limit  = r_reg_ol;
    assign app_regs          = r_app;
    assign app_reg_wr        = r_app_wr;
    assign RESET_OUT         = ~(&r_reset_timer);

endmodule

// File: tb/tb_vcr_regfile.sv
// Self-checking bench for vcr_regfile: transaction-level reference model feeding a scoreboard.
module tb_vcr_regfile;

    localparam int N  = 4;
    localparam int RB = 4;
    localparam int ED = 4;
    localparam int SB = 6;
    localparam int TW = 4;
    localparam logic [15:0] BT = 16'h0002;

    // ---------------- clock / reset / DUT ----------------
    logic              IFCLK = 1'b0;
    logic              RESET = 1'b1;
    logic              CS = 1'b1;
    logic [7:0]        vcr_in = 8'h00;
    logic              clk_vcr_addr = 1'b0;
    logic              clk_vcr_data = 1'b0;
    logic [2:0]        FPGA_ID = 3'd5;
    logic [8*SB-1:0]   status_in = 48'h0605_0403_0201;
    logic [15:0]       output_limit = 16'h1234;
    logic [7:0]        vcr_out;
    logic              hs_en;
    logic              output_mode_limit;
    logic [15:0]       output_limit_min;
    logic              reg_output_limit;
    logic [8*RB*N-1:0] app_regs;
    logic [N-1:0]      app_reg_wr;
    logic              RESET_OUT;

    vcr_regfile #(
        .N_APP_REGS(N), .REG_BYTES(RB), .ECHO_DEPTH(ED), .STATUS_BYTES(SB),
        .RESET_TIMER_W(TW), .BITSTREAM_TYPE(BT)
    ) dut (
        .IFCLK(IFCLK), .RESET(RESET), .CS(CS), .vcr_in(vcr_in), .vcr_out(vcr_out),
        .clk_vcr_addr(clk_vcr_addr), .clk_vcr_data(clk_vcr_data), .FPGA_ID(FPGA_ID),
        .status_in(status_in), .output_limit(output_limit), .hs_en(hs_en),
        .output_mode_limit(output_mode_limit), .output_limit_min(output_limit_min),
        .reg_output_limit(reg_output_limit), .app_regs(app_regs), .app_reg_wr(app_reg_wr),
        .RESET_OUT(RESET_OUT)
    );

    always #5 IFCLK = ~IFCLK;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [7:0]      exp_q[$];
    int              wr_idx_q[$];
    logic [8*RB-1:0] wr_val_q[$];
    logic rd_req = 1'b0;
    int ol_high_cycles = 0;

    // ---------------- reference model ----------------
    logic [7:0]  m_app [N][RB];
    logic [7:0]  m_shadow [RB];
    logic [7:0]  m_echo [ED];
    logic [2:0]  m_err = 3'b000;
    logic [7:0]  m_addr = 8'h00;
    int          m_idx = 0;
    logic        m_hs = 1'b0;
    logic        m_mode = 1'b1;
    logic [15:0] m_min = 16'h0000;
    int          m_ol_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8*RB-1:0] pack_app(input int i);
        logic [8*RB-1:0] v = '0;
        for (int b = 0; b < RB; b++) v[8*b +: 8] = m_app[i][b];
        return v;
    endfunction

    function automatic bit is_app(input logic [7:0] a);
        return (int'(a) >= 'h90) && (int'(a) < 'h90 + N);
    endfunction

    function automatic logic [7:0] model_read();
        logic [7:0] r = 8'h00;
        case (m_addr)
            8'h84: if (m_idx < SB) r = status_in[8*m_idx +: 8];
            8'h85: if (m_idx < 2) r = output_limit[8*m_idx +: 8];
            8'h88: r = m_echo[m_idx % ED] ^ 8'h5A;
            8'h8A: r = {5'b0, FPGA_ID};
            8'h8C: r = {5'b0, m_err};
            8'hA1: if (m_idx < 2) r = BT[8*m_idx +: 8];
            default: if (is_app(m_addr) && m_idx < RB) r = m_app[int'(m_addr) - 'h90][m_idx];
        endcase
        return r;
    endfunction

    task automatic model_soft_reset();
        m_addr = 8'h00; m_idx = 0; m_err = 3'b000; m_mode = 1'b1; m_min = 16'h0000;
        for (int i = 0; i < N; i++) for (int b = 0; b < RB; b++) m_app[i][b] = 8'h00;
    endtask

    task automatic model_addr(input logic [7:0] a);
        m_addr = a;
        m_idx = 0;
        for (int b = 0; b < RB; b++) m_shadow[b] = 8'h00;
        case (a)
            8'h80: m_hs = 1'b1;
            8'h81: m_hs = 1'b0;
            8'h86: m_mode = 1'b1;
            8'h87: m_mode = 1'b0;
            8'h85: m_ol_count++;
            8'h8B: model_soft_reset();
            8'h82, 8'h83, 8'h84, 8'h88, 8'h8A, 8'h8C, 8'hA1: ;
            default: if (!is_app(a)) m_err[0] = 1'b1;
        endcase
    endtask

    task automatic model_data(input logic [7:0] d);
        int i;
        if (m_addr == 8'h82) begin
            m_app[0][0] = d;
            wr_idx_q.push_back(0);
            wr_val_q.push_back(pack_app(0));
        end else if (m_addr == 8'h83) begin
            if (m_idx == 0) m_min[7:0] = d;
            else if (m_idx == 1) m_min[15:8] = d;
        end else if (m_addr == 8'h88) begin
            m_echo[m_idx % ED] = d;
        end else if (is_app(m_addr)) begin
            i = int'(m_addr) - 'h90;
            if (m_idx < RB) begin
                m_shadow[m_idx] = d;
                if (m_idx == RB - 1) begin
                    for (int b = 0; b < RB; b++) m_app[i][b] = m_shadow[b];
                    wr_idx_q.push_back(i);
                    wr_val_q.push_back(pack_app(i));
                end
            end else begin
                m_err[1] = 1'b1;
            end
        end
        m_idx++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic check_ctrl();
        check("hs_en", 32'(hs_en), 32'(m_hs));
        check("output_mode_limit", 32'(output_mode_limit), 32'(m_mode));
        check("output_limit_min", 32'(output_limit_min), 32'(m_min));
    endtask

    task automatic pulse_strobes(input logic [7:0] v, input bit a, input bit d);
        @(negedge IFCLK);
        vcr_in = v;
        clk_vcr_addr = a;
        clk_vcr_data = d;
        repeat (5) @(negedge IFCLK);
        clk_vcr_addr = 1'b0;
        clk_vcr_data = 1'b0;
        repeat (3) @(negedge IFCLK);
    endtask

    task automatic addr_xfer(input logic [7:0] a);
        model_addr(a);
        pulse_strobes(a, 1'b1, 1'b0);
        check_ctrl();
    endtask

    task automatic collide(input logic [7:0] a);
        m_err[2] = 1'b1;
        model_addr(a);
        pulse_strobes(a, 1'b1, 1'b1);
        check_ctrl();
    endtask

    task automatic data_xfer(input logic [7:0] d);
        exp_q.push_back(model_read());
        @(posedge IFCLK);
        #1 rd_req = 1'b1;
        @(posedge IFCLK);
        #1 rd_req = 1'b0;
        model_data(d);
        pulse_strobes(d, 1'b0, 1'b1);
    endtask

    // ---------------- monitor ----------------
    always @(negedge IFCLK) begin
        logic [7:0] e;
        int idx;
        logic [8*RB-1:0] v;
        if (rd_req) begin
            if (exp_q.size() == 0) begin
                check("read_unexpected", 32'(vcr_out), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("vcr_out_read", 32'(vcr_out), 32'(e));
            end
        end
        if (app_reg_wr != '0) begin
            if (wr_idx_q.size() == 0) begin
                check("commit_unexpected", 32'(app_reg_wr), 32'h0);
            end else begin
                idx = wr_idx_q.pop_front();
                v = wr_val_q.pop_front();
                check("app_reg_wr_pulse", 32'(app_reg_wr), 32'(1 << idx));
                check("app_regs_commit", app_regs[idx*8*RB +: 8*RB], v);
            end
        end
        if (reg_output_limit === 1'b1) ol_high_cycles++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    logic [7:0] addr_pool [20] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87,
                                   8'h88, 8'h8A, 8'h8C, 8'hA1, 8'h90, 8'h91, 8'h92, 8'h93,
                                   8'h94, 8'h7F, 8'hFF, 8'h8B};

    initial begin
        for (int i = 0; i < N; i++) for (int b = 0; b < RB; b++) m_app[i][b] = 8'h00;
        for (int b = 0; b < RB; b++) m_shadow[b] = 8'h00;
        for (int e = 0; e < ED; e++) m_echo[e] = 8'h00;

        repeat (3) @(posedge IFCLK);
        @(negedge IFCLK);
        RESET = 1'b0;
        check("reset_hs_en", 32'(hs_en), 32'h0);
        check("reset_mode_limit", 32'(output_mode_limit), 32'h1);
        check("reset_limit_min", 32'(output_limit_min), 32'h0);
        check("reset_reg_ol", 32'(reg_output_limit), 32'h0);
        check("reset_app_reg_wr", 32'(app_reg_wr), 32'h0);
        check("reset_vcr_out", 32'(vcr_out), 32'h0);
        for (int i = 0; i < N; i++) check("reset_app_regs", app_regs[i*8*RB +: 8*RB], 32'h0);
        for (int i = 0; i < 20; i++) begin
            check("reset_out_stretch", 32'(RESET_OUT), 32'(i < 15));
            @(negedge IFCLK);
        end

        // Full register write then readback.
        addr_xfer(8'h91);
        data_xfer(8'h11); data_xfer(8'h22); data_xfer(8'h33); data_xfer(8'h44);
        check("app_reg1_value", app_regs[1*8*RB +: 8*RB], 32'h4433_2211);
        addr_xfer(8'h91);
        data_xfer(8'h11); data_xfer(8'h22); data_xfer(8'h33); data_xfer(8'h44);

        // Partial write is abandoned; status window incl. one byte past the end.
        addr_xfer(8'h92);
        data_xfer(8'hAA); data_xfer(8'hBB);
        addr_xfer(8'h84);
        for (int i = 0; i < SB + 1; i++) data_xfer(8'(i));
        check("app_reg2_partial", app_regs[2*8*RB +: 8*RB], 32'h0);

        // Echo buffer.
        addr_xfer(8'h88);
        data_xfer(8'h01); data_xfer(8'h02); data_xfer(8'h03); data_xfer(8'h04);
        addr_xfer(8'h88);
        for (int i = 0; i < ED; i++) data_xfer(8'h00);

        // Collision, bad address, err readback, soft reset keeps hs_en.
        collide(8'h8C);
        addr_xfer(8'hFF);
        addr_xfer(8'h8C);
        data_xfer(8'h00);
        addr_xfer(8'h80);
        addr_xfer(8'h8B);
        check("soft_reset_out_high", 32'(RESET_OUT), 32'h1);
        addr_xfer(8'h8C);
        data_xfer(8'h00);

        // Output-limit pulse and readback.
        addr_xfer(8'h85);
        data_xfer(8'h00); data_xfer(8'h00);

        // Strobes with CS low are ignored.
        CS = 1'b0;
        pulse_strobes(8'h81, 1'b1, 1'b0);
        CS = 1'b1;
        check_ctrl();

        // Randomised transactions.
        for (int t = 0; t < 60; t++) begin
            logic [7:0] a;
            int nd;
            status_in = {16'($urandom), 32'($urandom)};
            output_limit = 16'($urandom);
            FPGA_ID = 3'($urandom);
            a = addr_pool[$urandom_range(0, 19)];
            if ($urandom_range(0, 7) == 0) collide(a);
            else addr_xfer(a);
            nd = $urandom_range(0, 6);
            for (int k = 0; k < nd; k++) data_xfer(8'($urandom));
        end

        repeat (5) @(negedge IFCLK);
        for (int i = 0; i < N; i++) check("final_app_regs", app_regs[i*8*RB +: 8*RB], pack_app(i));
        check("reg_output_limit_cycles", 32'(ol_high_cycles), 32'(m_ol_count));
        check("pending_reads", 32'(exp_q.size()), 32'h0);
        check("pending_commits", 32'(wr_idx_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
